// File: rtl/router_ingress_ctrl.sv
// Ingress controller for the 1x3 router. It decodes the header, steers header,
// payload and parity bytes into the selected FIFO and flags parity or length errors.
module router_ingress_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    output logic [7:0] data_out,
    output logic [2:0] wr_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic       err
);

    // state              | meaning
    // ST_IDLE            | waiting for a header byte
    // ST_WAIT_TILL_EMPTY | header held until the destination FIFO drains
    // ST_LOAD_FIRST_DATA | header written to the FIFO, marked by lfd_state
    // ST_LOAD_DATA       | payload/parity pass-through, stalled while full
    // ST_CHECK_PARITY    | one-cycle turnaround after the parity byte
    // ST_DROP            | invalid destination, bytes consumed and discarded
    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_WAIT_TILL_EMPTY = 3'd1,
        ST_LOAD_FIRST_DATA = 3'd2,
        ST_LOAD_DATA       = 3'd3,
        ST_CHECK_PARITY    = 3'd4,
        ST_DROP            = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] par_q, par_d;
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic [2:0] dest_oh;
    logic [2:0] new_dest_oh;
    logic       dest_full;
    logic       dest_empty;
    logic       new_dest_empty;

    function automatic logic [2:0] onehot3(input logic [1:0] d);
        case (d)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Destination 3 decodes to no FIFO, so it can never select a flag or a write.
    assign dest_oh        = onehot3(hdr_q[1:0]);
    assign new_dest_oh    = onehot3(data_in[1:0]);
    assign dest_full      = |(fifo_full & dest_oh);
    assign dest_empty     = |(fifo_empty & dest_oh);
    assign new_dest_empty = |(fifo_empty & new_dest_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= 8'h00;
            par_q   <= 8'h00;
            cnt_q   <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    hdr_d = data_in;
                    par_d = data_in;
                    cnt_d = 7'd0;
                    err_d = 1'b0;
                    if (data_in[1:0] == 2'd3)
                        state_d = ST_DROP;
                    else if (new_dest_empty)
                        state_d = ST_LOAD_FIRST_DATA;
                    else
                        state_d = ST_WAIT_TILL_EMPTY;
                end
            end
            ST_WAIT_TILL_EMPTY: begin
                if (dest_empty)
                    state_d = ST_LOAD_FIRST_DATA;
            end
            ST_LOAD_FIRST_DATA: state_d = ST_LOAD_DATA;
            ST_LOAD_DATA: begin
                if (!dest_full) begin
                    if (pkt_valid) begin
                        par_d = par_q ^ data_in;
                        cnt_d = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
                    end else begin
                        err_d   = (data_in != par_q) || (cnt_q != {1'b0, hdr_q[7:2]});
                        state_d = ST_CHECK_PARITY;
                    end
                end
            end
            ST_CHECK_PARITY: state_d = ST_IDLE;
            ST_DROP: begin
                if (!pkt_valid) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_out  = 8'h00;
        wr_enb    = 3'b000;
        lfd_state = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_WAIT_TILL_EMPTY: busy = 1'b1;
            ST_LOAD_FIRST_DATA: begin
                busy      = 1'b1;
                data_out  = hdr_q;
                lfd_state = 1'b1;
                wr_enb    = dest_oh;
            end
            ST_LOAD_DATA: begin
                busy     = dest_full;
                data_out = data_in;
                wr_enb   = dest_full ? 3'b000 : dest_oh;
            end
            ST_CHECK_PARITY: busy = 1'b1;
            default: begin
                data_out  = 8'h00;
                wr_enb    = 3'b000;
                lfd_state = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Bench for router_ingress_ctrl: directed per-cycle vector table, mid-packet
// reset, and random packets checked against a packet-level scoreboard.
`timescale 1ns/1ps
module tb_router_ingress_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [7:0] data_out;
    logic [2:0] wr_enb;
    logic       lfd_state;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_ingress_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .data_out   (data_out),
        .wr_enb     (wr_enb),
        .lfd_state  (lfd_state),
        .busy       (busy),
        .err        (err)
    );

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] d;
        logic       lfd;
    } wr_t;

    typedef struct {
        logic       pv;
        logic [7:0] d;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] we;
        logic [7:0] dout;
        logic       lfd;
        logic       busy;
        logic       err;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tv[$];
    logic err_exp = 1'b0;
    logic sb_en   = 1'b0;
    logic rand_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [7:0] d, input logic [2:0] full,
                       input logic [2:0] empty, input logic [2:0] we, input logic [7:0] dout,
                       input logic lfd, input logic bsy, input logic e);
        vec_t v;
        v.pv = pv; v.d = d; v.full = full; v.empty = empty;
        v.we = we; v.dout = dout; v.lfd = lfd; v.busy = bsy; v.err = e;
        tv.push_back(v);
    endtask

    // Every FIFO write must be the next byte the packet model predicts.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (wr_enb != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got we=%b d=%h lfd=%b required no write",
                             wr_enb, data_out, lfd_state);
                end else begin
                    chk("write", 32'({wr_enb, data_out, lfd_state}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("lfd_without_write", 32'(lfd_state), 32'(0));
            end
            chk("err", 32'(err), 32'(err_exp));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                for (int i = 0; i < 3; i++) begin
                    fifo_full[i]  = ($urandom_range(0, 3) == 0);
                    fifo_empty[i] = ($urandom_range(0, 1) == 1);
                end
            end
        end
    end

    // Drives one packet (header, payloads, parity) honouring busy, and records
    // the writes and error result the packet rules predict.
    task automatic send_pkt(input logic [7:0] b[$]);
        logic [7:0] px;
        int         n;
        logic       e;
        int         cyc;
        logic       acc;
        n  = b.size() - 2;
        px = 8'h00;
        for (int i = 0; i < b.size() - 1; i++) px ^= b[i];
        if (b[0][1:0] == 2'd3) begin
            e = 1'b1;
        end else begin
            e = (b[b.size()-1] != px) || (n != int'(b[0][7:2]));
            for (int i = 0; i < b.size(); i++)
                exp_q.push_back({3'(1 << b[0][1:0]), b[i], (i == 0)});
        end
        for (int i = 0; i < b.size(); i++) begin
            pkt_valid = (i != b.size() - 1);
            data_in   = b[i];
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 500) begin
                @(negedge clk);
                acc = !busy;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: byte %0d of header %h never accepted", i, b[0]);
            end
            if (i == 0) err_exp = 1'b0;
            if (i == b.size() - 1) err_exp = e;
        end
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        chk("pkt_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [5:0] len;
        logic [1:0] dst;
        logic [7:0] par;
        logic [7:0] x;
        int         n;

        rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        fifo_full = 3'b000; fifo_empty = 3'b111;
        #1;
        chk("rst_outputs", 32'({data_out, wr_enb, lfd_state, busy, err}), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // pv, data, full, empty | wr_enb, data_out, lfd, busy, err
        add(1, 8'h0D, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(1, 8'h11, 0, 7, 3'b010, 8'h0D, 1, 1, 0);
        add(1, 8'h11, 0, 7, 3'b010, 8'h11, 0, 0, 0);
        add(1, 8'h22, 0, 7, 3'b010, 8'h22, 0, 0, 0);
        add(1, 8'h33, 0, 7, 3'b010, 8'h33, 0, 0, 0);
        add(0, 8'h0D, 0, 7, 3'b010, 8'h0D, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(1, 8'h0D, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(1, 8'h11, 0, 7, 3'b010, 8'h0D, 1, 1, 0);
        add(1, 8'h11, 0, 7, 3'b010, 8'h11, 0, 0, 0);
        add(1, 8'h22, 0, 7, 3'b010, 8'h22, 0, 0, 0);
        add(1, 8'h33, 0, 7, 3'b010, 8'h33, 0, 0, 0);
        add(0, 8'h0E, 0, 7, 3'b010, 8'h0E, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 1, 1);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 0, 1);
        add(1, 8'h08, 0, 7, 3'b000, 8'h00, 0, 0, 1);
        add(1, 8'hAA, 0, 7, 3'b001, 8'h08, 1, 1, 0);
        add(1, 8'hAA, 1, 7, 3'b000, 8'hAA, 0, 1, 0);
        add(1, 8'hAA, 1, 7, 3'b000, 8'hAA, 0, 1, 0);
        add(1, 8'hAA, 1, 7, 3'b000, 8'hAA, 0, 1, 0);
        add(1, 8'hAA, 0, 7, 3'b001, 8'hAA, 0, 0, 0);
        add(1, 8'hBB, 0, 7, 3'b001, 8'hBB, 0, 0, 0);
        add(0, 8'h19, 0, 7, 3'b001, 8'h19, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 1, 0);
        add(1, 8'h06, 0, 3, 3'b000, 8'h00, 0, 0, 0);
        add(1, 8'h5A, 0, 3, 3'b000, 8'h00, 0, 1, 0);
        add(1, 8'h5A, 0, 3, 3'b000, 8'h00, 0, 1, 0);
        add(1, 8'h5A, 0, 7, 3'b000, 8'h00, 0, 1, 0);
        add(1, 8'h5A, 0, 7, 3'b100, 8'h06, 1, 1, 0);
        add(1, 8'h5A, 0, 7, 3'b100, 8'h5A, 0, 0, 0);
        add(0, 8'h5C, 0, 7, 3'b100, 8'h5C, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 1, 0);
        add(1, 8'h07, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(1, 8'h77, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 7, 3'b000, 8'h00, 0, 0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            pkt_valid  = tv[i].pv;
            data_in    = tv[i].d;
            fifo_full  = tv[i].full;
            fifo_empty = tv[i].empty;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({wr_enb, data_out, lfd_state, busy, err}),
                32'({tv[i].we, tv[i].dout, tv[i].lfd, tv[i].busy, tv[i].err}));
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        data_in   = 8'h00;

        err_exp = 1'b1;
        sb_en   = 1'b1;
        rand_en = 1'b1;
        for (int p = 0; p < 80; p++) begin
            q.delete();
            len = 6'($urandom_range(0, 12));
            dst = 2'($urandom_range(0, 3));
            n   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : int'(len);
            q.push_back({len, dst});
            par = {len, dst};
            for (int k = 0; k < n; k++) begin
                x = 8'($urandom);
                q.push_back(x);
                par ^= x;
            end
            if ($urandom_range(0, 4) == 0) par ^= 8'($urandom_range(1, 255));
            q.push_back(par);
            send_pkt(q);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        sb_en   = 1'b0;
        rand_en = 1'b0;
        @(posedge clk); #1;
        fifo_full = 3'b000; fifo_empty = 3'b111;
        repeat (3) begin @(posedge clk); #1; end

        // Reset lands while payload 2 is on the bus.
        pkt_valid = 1'b1; data_in = 8'h0D;
        @(posedge clk); #1;
        data_in = 8'h11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in = 8'h22;
        #1;
        chk("pre_rst_write", 32'({wr_enb, data_out}), 32'({3'b010, 8'h22}));
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({data_out, wr_enb, lfd_state, busy, err}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        pkt_valid = 1'b0;
        data_in = 8'h00;
        exp_q.delete();
        err_exp = 1'b0;
        sb_en = 1'b1;
        q.delete();
        q.push_back(8'h0D); q.push_back(8'h11); q.push_back(8'h22);
        q.push_back(8'h33); q.push_back(8'h0D);
        send_pkt(q);
        repeat (2) begin @(posedge clk); #1; end
        chk("post_rst_err", 32'(err), 32'(0));
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
